commit_store_buffer: RTL and testbench
======================================

# commit_store_buffer

Post-commit store buffer between `stage_retire` and the D-cache. It accepts at most one committed store per cycle from retire and holds it in a FIFO. It drains the oldest entry to the D-cache through a request/accept/done handshake, so a cache miss no longer stalls retirement. Committed entries are architectural state: they survive branch mispredicts and are only cleared by reset.

## Interface
Parameters:
- `DEPTH`, 4 — entry count; a power of two, at least 2.
- `CNT_W`, `$clog2(DEPTH+1)` — width of the occupancy count.

Ports:
- `clock` input 1 — clock; all state updates on the rising edge.
- `reset` input 1 — asynchronous, active-high.
- `enq_valid` input 1 — retire presents a committed store.
- `enq_addr` input ADDR — byte address, naturally aligned for its size.
- `enq_data` input DATA — store data in RV register layout (low bytes).
- `enq_size` input 2 — 0 = byte, 1 = half, 2 = word; 3 is illegal and is dropped.
- `enq_pc` input ADDR — PC of the store, for debug.
- `enq_ready` output 1 — `count != DEPTH`; registered-state based.
- `dc_req_valid` output 1 — head store is offered to the D-cache.
- `dc_req_addr` output ADDR — head address.
- `dc_req_data` output DATA — head data.
- `dc_req_size` output 2 — head size.
- `dc_req_pc` output ADDR — head PC.
- `dc_req_accept` input 1 — the cache took the request this cycle.
- `dc_done` input 1 — the accepted store has been written into the cache.
- `ld_addr` input ADDR — load probe address.
- `ld_size` input 2 — load probe size.
- `ld_conflict` output 1 — the load must stall and retry.
- `ld_fwd_valid` output 1 — forwarded data is valid (macro-dependent).
- `ld_fwd_data` output DATA — forwarded word, aligned to `ld_addr[1:0]`.
- `count` output CNT_W — number of occupied entries.
- `empty` output 1 — `count == 0`; retire holds halt commit until this is 1.

## Operation
- Storage:
  - `DEPTH` entries holding {addr, data, size, pc, bytemask}.
  - `bytemask` = {1, 3, 15}[size] << addr[1:0], computed at enqueue.
  - Head and tail pointers wrap modulo DEPTH.
- Enqueue: when `enq_valid && enq_ready`, write the tail entry, advance tail, and increment count.
- Drain FSM, one store in flight:
  - IDLE: `dc_req_valid` = 0. Go to ISSUE when count > 0.
  - ISSUE: `dc_req_valid` = 1, and the head fields are held stable. On `dc_req_accept`, go to WAIT.
  - WAIT: `dc_req_valid` = 0. On `dc_done`, pop the head (advance head, decrement count). Then go to ISSUE if the post-pop count > 0, else IDLE.
  - `dc_done` outside WAIT is ignored.
- Simultaneous enqueue and pop:
  - Count is unchanged; both pointers advance.
  - When full, an enqueue is refused even if a pop happens in the same cycle. There is no bypass.
- Load probe (combinational):
  - Covers every occupied entry, including the in-flight head.
  - Excludes the store being enqueued in the same cycle.
  - An entry matches when `addr[31:2]` is equal and `bytemask & ld_mask != 0`.
- Mispredict or flush has no effect on this block.
- Reset mid-drain: the FSM returns to IDLE and buffered stores are discarded.

## Timing
- Reset values:
  - count = 0, head = tail = 0, FSM = IDLE.
  - `dc_req_valid` = 0, `enq_ready` = 1, `empty` = 1.
  - `ld_conflict` = `ld_fwd_valid` = 0, and all data outputs = 0.
- Enqueue to `dc_req_valid` on an empty buffer: 1 cycle (the request is asserted the cycle after the enqueue edge).
- Back-to-back drain: with `dc_req_accept` and `dc_done` each asserted in the first cycle they are looked at, a store drains every 2 cycles.
- `dc_done` to next `dc_req_valid`: 1 cycle.
- `enq_ready`, `count` and `empty` are functions of registered state only.
- Probe outputs are same-cycle combinational.

## Configuration
- `SB_FORWARD_EN` defined:
  - Find the youngest matching entry.
  - If its bytemask covers the load mask, then `ld_fwd_valid` = 1, `ld_fwd_data` = its data shifted to lane position, and `ld_conflict` = 0.
  - Otherwise `ld_conflict` = 1.
- Not defined:
  - `ld_fwd_valid` and `ld_fwd_data` are tied to 0.
  - `ld_conflict` = 1 on any match.

## Test plan
- Reset, then enqueue a word store at 0x100 with data 0xDEADBEEF.
  - Expect `dc_req_valid` = 1 the next cycle with addr 0x100 and data 0xDEADBEEF.
  - Assert accept, then done two cycles later. Expect count 1→0, `empty` = 1, FSM back in IDLE.
- Fill 4 stores while accept is held low.
  - Expect `enq_ready` = 0 and count = 4.
  - Drive a 5th `enq_valid` in the same cycle as a pop. It must be refused, leaving count = 3.
- Hold `dc_req_accept` low for 5 cycles.
  - `dc_req_addr` and `dc_req_data` must stay stable.
  - Assert accept; later `dc_done` pops exactly one entry, in FIFO order.
- Probe: buffer holds a byte store at 0x203 (data 0xAB) followed by a word store at 0x200 (data 0x11223344). Load word at 0x200.
  - With the macro: `ld_fwd_valid` = 1, `ld_fwd_data` = 0x11223344.
  - Without the macro: `ld_conflict` = 1.
  - A load word at 0x204 gives no conflict in either build.
- With the macro, buffer holds only a byte store at 0x203.
  - Load word at 0x200: `ld_conflict` = 1, `ld_fwd_valid` = 0.
  - Load byte at 0x203: `ld_fwd_data[31:24]` = 0xAB.
- Assert `reset` asynchronously while the FSM is in WAIT with 3 entries buffered.
  - Outputs take reset values immediately.
  - After reset deasserts, no `dc_req_valid` is driven.

Source files
------------

// File: rtl/commit_store_buffer.sv
// commit_store_buffer: post-commit store FIFO between retire and the D-cache.
// Drains the oldest store through a req/accept/done handshake, one in flight,
// and answers combinational load probes against every buffered store.
// Build option: define SB_FORWARD_EN to forward data from the youngest
// covering store; otherwise any overlapping store raises ld_conflict.
module commit_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  input  logic [31:0]       enq_addr,
  input  logic [31:0]       enq_data,
  input  logic [1:0]        enq_size,
  input  logic [31:0]       enq_pc,
  output logic              enq_ready,
  output logic              dc_req_valid,
  output logic [31:0]       dc_req_addr,
  output logic [31:0]       dc_req_data,
  output logic [1:0]        dc_req_size,
  output logic [31:0]       dc_req_pc,
  input  logic              dc_req_accept,
  input  logic              dc_done,
  input  logic [31:0]       ld_addr,
  input  logic [1:0]        ld_size,
  output logic              ld_conflict,
  output logic              ld_fwd_valid,
  output logic [31:0]       ld_fwd_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        size;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        mask;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Byte lanes touched by an access; size 3 touches nothing.
  function automatic logic [3:0] size_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m << off;
  endfunction

  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;

  logic enq_fire;
  logic pop;

  assign enq_ready = (count_q != CNT_W'(DEPTH));
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign enq_fire  = enq_valid && enq_ready && (enq_size != 2'd3);
  assign pop       = (state_q == ST_WAIT) && dc_done;

  assign dc_req_valid = (state_q == ST_ISSUE);
  assign dc_req_addr  = entries_q[head_q].addr;
  assign dc_req_data  = entries_q[head_q].data;
  assign dc_req_size  = entries_q[head_q].size;
  assign dc_req_pc    = entries_q[head_q].pc;

  // Next-state: FIFO write/pop, occupancy and drain FSM.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    state_d   = state_q;

    if (enq_fire) begin
      entries_d[tail_q].addr = enq_addr;
      entries_d[tail_q].data = enq_data;
      entries_d[tail_q].size = enq_size;
      entries_d[tail_q].pc   = enq_pc;
      entries_d[tail_q].mask = size_mask(enq_size, enq_addr[1:0]);
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({enq_fire, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Decisions use the post-update count so a new store is offered next cycle.
    case (state_q)
      ST_IDLE:  if (count_d != '0) state_d = ST_ISSUE;
      ST_ISSUE: if (dc_req_accept) state_d = ST_WAIT;
      ST_WAIT:  if (dc_done) state_d = (count_d != '0) ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards all buffered stores.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      state_q   <= state_d;
    end
  end

  logic [3:0]       ld_mask;
  logic             hit_any;
`ifdef SB_FORWARD_EN
  logic [3:0]       hit_mask;
  logic [DATA_W-1:0] hit_data;
`endif

  // Load probe: scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = head_q;
    ld_mask = size_mask(ld_size, ld_addr[1:0]);
    hit_any = 1'b0;
`ifdef SB_FORWARD_EN
    hit_mask = '0;
    hit_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) &&
          (entries_q[idx].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) &&
          ((entries_q[idx].mask & ld_mask) != 4'b0000)) begin
        hit_any = 1'b1;
`ifdef SB_FORWARD_EN
        hit_mask = entries_q[idx].mask;
        hit_data = entries_q[idx].data << {entries_q[idx].addr[1:0], 3'b000};
`endif
      end
    end
  end

`ifdef SB_FORWARD_EN
  logic fwd_cover;
  assign fwd_cover    = hit_any && ((hit_mask & ld_mask) == ld_mask);
  assign ld_fwd_valid = fwd_cover;
  assign ld_fwd_data  = fwd_cover ? hit_data : '0;
  assign ld_conflict  = hit_any && !fwd_cover;
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
  assign ld_conflict  = hit_any;
`endif

endmodule

// File: tb/tb_commit_store_buffer.sv
// Directed bench for commit_store_buffer: drain handshake, full/refuse,
// FIFO order, load probe tables for either build, async reset mid-drain.
module tb_commit_store_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid;
  logic [31:0] enq_addr, enq_data, enq_pc;
  logic [1:0]  enq_size;
  logic        enq_ready;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr, dc_req_data, dc_req_pc;
  logic [1:0]  dc_req_size;
  logic        dc_req_accept, dc_done;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_conflict, ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int failures = 0;

  commit_store_buffer #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data),
    .enq_size(enq_size), .enq_pc(enq_pc), .enq_ready(enq_ready),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_size(dc_req_size), .dc_req_pc(dc_req_pc),
    .dc_req_accept(dc_req_accept), .dc_done(dc_done),
    .ld_addr(ld_addr), .ld_size(ld_size), .ld_conflict(ld_conflict),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        conflict;
    logic        fwd_valid;
    logic [31:0] fwd_data;
  } probe_vec_t;

  probe_vec_t tab_a [5];
  probe_vec_t tab_b [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_size = s; enq_pc = a + 32'h1000;
    step();
    enq_valid = 1'b0;
  endtask

  task automatic run_probe(input probe_vec_t v, input string tag);
    ld_addr = v.addr; ld_size = v.size;
    #1;
    chk({tag, "_conflict"}, 32'(ld_conflict), 32'(v.conflict));
    chk({tag, "_fwd_valid"}, 32'(ld_fwd_valid), 32'(v.fwd_valid));
    chk({tag, "_fwd_data"}, ld_fwd_data, v.fwd_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Buffer {byte 0x203=AB, word 0x200=11223344}; youngest (word) covers.
`ifdef SB_FORWARD_EN
    tab_a[0] = '{32'h200, 2'd2, 1'b0, 1'b1, 32'h11223344};
    tab_a[1] = '{32'h204, 2'd2, 1'b0, 1'b0, 32'h0};
    tab_a[2] = '{32'h203, 2'd0, 1'b0, 1'b1, 32'h11223344};
    tab_a[3] = '{32'h202, 2'd1, 1'b0, 1'b1, 32'h11223344};
    tab_a[4] = '{32'h1FC, 2'd2, 1'b0, 1'b0, 32'h0};
    // Buffer {byte 0x203=AB} only.
    tab_b[0] = '{32'h200, 2'd2, 1'b1, 1'b0, 32'h0};
    tab_b[1] = '{32'h203, 2'd0, 1'b0, 1'b1, 32'hAB000000};
    tab_b[2] = '{32'h200, 2'd0, 1'b0, 1'b0, 32'h0};
    tab_b[3] = '{32'h202, 2'd1, 1'b1, 1'b0, 32'h0};
`else
    tab_a[0] = '{32'h200, 2'd2, 1'b1, 1'b0, 32'h0};
    tab_a[1] = '{32'h204, 2'd2, 1'b0, 1'b0, 32'h0};
    tab_a[2] = '{32'h203, 2'd0, 1'b1, 1'b0, 32'h0};
    tab_a[3] = '{32'h202, 2'd1, 1'b1, 1'b0, 32'h0};
    tab_a[4] = '{32'h1FC, 2'd2, 1'b0, 1'b0, 32'h0};
    tab_b[0] = '{32'h200, 2'd2, 1'b1, 1'b0, 32'h0};
    tab_b[1] = '{32'h203, 2'd0, 1'b1, 1'b0, 32'h0};
    tab_b[2] = '{32'h200, 2'd0, 1'b0, 1'b0, 32'h0};
    tab_b[3] = '{32'h202, 2'd1, 1'b1, 1'b0, 32'h0};
`endif

    reset = 1'b1;
    enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_size = '0; enq_pc = '0;
    dc_req_accept = 1'b0; dc_done = 1'b0;
    ld_addr = 32'h0; ld_size = 2'd2;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_req_valid", 32'(dc_req_valid), 32'd0);
    chk("rst_req_addr", dc_req_addr, 32'h0);
    chk("rst_conflict", 32'(ld_conflict), 32'd0);
    chk("rst_fwd_valid", 32'(ld_fwd_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();

    // Single store: request appears the cycle after the enqueue edge.
    enq(32'h100, 32'hDEADBEEF, 2'd2);
    chk("t1_req_valid", 32'(dc_req_valid), 32'd1);
    chk("t1_req_addr", dc_req_addr, 32'h100);
    chk("t1_req_data", dc_req_data, 32'hDEADBEEF);
    chk("t1_req_size", 32'(dc_req_size), 32'd2);
    chk("t1_req_pc", dc_req_pc, 32'h1100);
    chk("t1_count1", 32'(count), 32'd1);
    dc_req_accept = 1'b1;
    step();
    dc_req_accept = 1'b0;
    chk("t1_wait_valid", 32'(dc_req_valid), 32'd0);
    step();
    dc_done = 1'b1;
    chk("t1_count_pre_done", 32'(count), 32'd1);
    step();
    dc_done = 1'b0;
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_idle_valid", 32'(dc_req_valid), 32'd0);
    step();
    chk("t1_idle_valid2", 32'(dc_req_valid), 32'd0);

    // Illegal size is dropped.
    enq(32'h500, 32'h55, 2'd3);
    chk("illegal_size_count", 32'(count), 32'd0);

    // Fill with accept low; head must stay stable while not accepted.
    for (int i = 0; i < 4; i++) enq(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 2'd2);
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("hold_addr", dc_req_addr, 32'h10);
      chk("hold_data", dc_req_data, 32'hA0);
      step();
    end
    dc_req_accept = 1'b1;
    step();
    dc_req_accept = 1'b0;
    // Fifth enqueue in the same cycle as a pop: refused.
    dc_done = 1'b1;
    enq_valid = 1'b1; enq_addr = 32'h20; enq_data = 32'hEE; enq_size = 2'd2;
    step();
    dc_done = 1'b0; enq_valid = 1'b0;
    chk("refuse_count", 32'(count), 32'd3);
    chk("refuse_valid", 32'(dc_req_valid), 32'd1);
    // Drain remaining entries in FIFO order, 2 cycles each.
    for (int i = 1; i < 4; i++) begin
      chk("fifo_addr", dc_req_addr, 32'h10 + 32'(4 * i));
      chk("fifo_data", dc_req_data, 32'hA0 + 32'(i));
      dc_req_accept = 1'b1;
      step();
      dc_req_accept = 1'b0; dc_done = 1'b1;
      step();
      dc_done = 1'b0;
      chk("fifo_count", 32'(count), 32'(3 - i));
    end
    chk("drained_empty", 32'(empty), 32'd1);
    chk("drained_valid", 32'(dc_req_valid), 32'd0);

    // Probe table A.
    enq(32'h203, 32'hAB, 2'd0);
    enq(32'h200, 32'h11223344, 2'd2);
    for (int i = 0; i < 5; i++) run_probe(tab_a[i], $sformatf("probeA%0d", i));
    for (int i = 0; i < 2; i++) begin
      dc_req_accept = 1'b1;
      step();
      dc_req_accept = 1'b0; dc_done = 1'b1;
      step();
      dc_done = 1'b0;
    end
    chk("probeA_drained", 32'(count), 32'd0);

    // Probe table B against an in-flight (WAIT) head.
    enq(32'h203, 32'hAB, 2'd0);
    dc_req_accept = 1'b1;
    step();
    dc_req_accept = 1'b0;
    for (int i = 0; i < 4; i++) run_probe(tab_b[i], $sformatf("probeB%0d", i));

    // The store being enqueued this cycle is not seen by the probe.
    enq_valid = 1'b1; enq_addr = 32'h300; enq_data = 32'h33; enq_size = 2'd2;
    ld_addr = 32'h300; ld_size = 2'd2;
    #1;
    chk("probe_excl_enq", 32'(ld_conflict | ld_fwd_valid), 32'd0);
    step();
    enq_valid = 1'b0;
    enq(32'h304, 32'h44, 2'd2);
    chk("wait3_count", 32'(count), 32'd3);
    chk("wait3_valid", 32'(dc_req_valid), 32'd0);
    ld_addr = 32'h203; ld_size = 2'd0;

    // Asynchronous reset mid-drain.
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_enq_ready", 32'(enq_ready), 32'd1);
    chk("arst_req_addr", dc_req_addr, 32'h0);
    chk("arst_conflict", 32'(ld_conflict), 32'd0);
    step();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_valid", 32'(dc_req_valid), 32'd0);
    end
    chk("post_rst_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
